// File: rtl/cr_pmp_chk_pkg.sv
// Shared constants and types for the pipelined PMP permission checker.
package cr_pmp_chk_pkg;

    localparam logic [1:0] PRIV_M = 2'b11;

    typedef struct packed {
        logic lsu;
        logic st;
        logic nohit;
    } rec_flags_t;

    function automatic bit pmp_cfg_legal(input int nreg, input int idxw);
        return (nreg >= 1) && (nreg <= 16) && ((1 << idxw) >= nreg);
    endfunction

endpackage

// File: rtl/cr_pmp_chk_chan.sv
// One PMP check channel: priority encoder, deny rule and a one-entry result stage.
module cr_pmp_chk_chan
    import cr_pmp_chk_pkg::*;
#(
    parameter int NREG = 8,
    parameter int IDXW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_vld,
    output logic            req_rdy,
    input  logic [NREG-1:0] hit,
    input  logic [NREG-1:0] perm,
    input  logic [NREG-1:0] lock,
    input  logic            priv_m,
    input  logic            rsp_rdy,
    output logic            rsp_vld,
    output logic            rsp_deny,
    output logic            acc,
    output logic            acc_deny,
    output logic            acc_nohit,
    output logic [IDXW-1:0] acc_idx
);

    logic            rsp_vld_d, rsp_vld_q;
    logic            rsp_deny_d, rsp_deny_q;
    logic            sel_perm, sel_lock;
    logic [IDXW-1:0] sel_idx;

    // Descending scan so the lowest set hit bit is the one left standing.
    always_comb begin
        sel_idx  = '0;
        sel_perm = 1'b0;
        sel_lock = 1'b0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel_idx  = IDXW'(i);
                sel_perm = perm[i];
                sel_lock = lock[i];
            end
        end
    end

    always_comb begin
        acc_nohit = ~|hit;
        acc_idx   = sel_idx;
        if (acc_nohit) begin
            acc_deny = !priv_m;
        end else if (priv_m && !sel_lock) begin
            acc_deny = 1'b0;
        end else begin
            acc_deny = !sel_perm;
        end
    end

    assign req_rdy = !rsp_vld_q || rsp_rdy;
    assign acc     = req_vld && req_rdy;

    always_comb begin
        rsp_vld_d  = rsp_vld_q;
        rsp_deny_d = rsp_deny_q;
        if (acc) begin
            rsp_vld_d  = 1'b1;
            rsp_deny_d = acc_deny;
        end else if (rsp_rdy) begin
            rsp_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_q  <= 1'b0;
            rsp_deny_q <= 1'b0;
        end else begin
            rsp_vld_q  <= rsp_vld_d;
            rsp_deny_q <= rsp_deny_d;
        end
    end

    assign rsp_vld  = rsp_vld_q;
    assign rsp_deny = rsp_deny_q;

endmodule

// File: rtl/cr_pmp_chk_pipe.sv
// Registered PMP checker for IFU and LSU with a sticky first-fault record and deny counter.
module cr_pmp_chk_pipe
    import cr_pmp_chk_pkg::*;
#(
    parameter int NREG = 8,
    parameter int IDXW = 4,
    parameter int CNTW = 16
) (
    input  logic            forever_cpuclk,
    input  logic            cpurst_b,
    input  logic [1:0]      cp0_pmp_mstatus_mpp,
    input  logic            cp0_pmp_mstatus_mprv,
    input  logic            cp0_yy_machine_mode_aft_dbg,
    input  logic            cp0_pmp_rec_clr,
    input  logic [NREG-1:0] regs_comp_read,
    input  logic [NREG-1:0] regs_comp_write,
    input  logic [NREG-1:0] regs_comp_excut,
    input  logic [NREG-1:0] regs_comp_lock,
    input  logic            ifu_pmp_req_vld,
    output logic            ifu_pmp_req_rdy,
    input  logic [NREG-1:0] ifu_pmp_hit,
    input  logic            ifu_pmp_mmode,
    input  logic            lsu_pmp_req_vld,
    output logic            lsu_pmp_req_rdy,
    input  logic [NREG-1:0] lsu_pmp_hit,
    input  logic            lsu_pmp_is_st,
    output logic            pmp_ifu_rsp_vld,
    input  logic            ifu_pmp_rsp_rdy,
    output logic            pmp_ifu_deny,
    output logic            pmp_lsu_rsp_vld,
    input  logic            lsu_pmp_rsp_rdy,
    output logic            pmp_lsu_deny,
    output logic            pmp_cp0_rec_vld,
    output logic            pmp_cp0_rec_lsu,
    output logic            pmp_cp0_rec_st,
    output logic            pmp_cp0_rec_nohit,
    output logic [IDXW-1:0] pmp_cp0_rec_idx,
    output logic [CNTW-1:0] pmp_cp0_deny_cnt
);

    if (!pmp_cfg_legal(NREG, IDXW)) begin : g_cfg_err
        $error("cr_pmp_chk_pipe: NREG must be 1..16 and fit in IDXW bits");
    end

    localparam int SUMW = CNTW + 1;

    logic            lsu_priv_m;
    logic            ifu_acc, ifu_acc_deny, ifu_acc_nohit;
    logic            lsu_acc, lsu_acc_deny, lsu_acc_nohit;
    logic [IDXW-1:0] ifu_acc_idx, lsu_acc_idx;
    logic            ifu_den, lsu_den;

    logic            rec_vld_d, rec_vld_q, rec_vld_base;
    rec_flags_t      rec_flags_d, rec_flags_q;
    logic [IDXW-1:0] rec_idx_d, rec_idx_q;
    logic [CNTW-1:0] cnt_d, cnt_q, cnt_base;
    logic [SUMW-1:0] cnt_sum;

    // MPRV redirects LSU checks to the privilege held in MPP.
    assign lsu_priv_m = cp0_pmp_mstatus_mprv ? (cp0_pmp_mstatus_mpp == PRIV_M)
                                             : cp0_yy_machine_mode_aft_dbg;

    cr_pmp_chk_chan #(.NREG(NREG), .IDXW(IDXW)) u_ifu_chan (
        .clk       (forever_cpuclk),
        .rst_n     (cpurst_b),
        .req_vld   (ifu_pmp_req_vld),
        .req_rdy   (ifu_pmp_req_rdy),
        .hit       (ifu_pmp_hit),
        .perm      (regs_comp_excut),
        .lock      (regs_comp_lock),
        .priv_m    (ifu_pmp_mmode),
        .rsp_rdy   (ifu_pmp_rsp_rdy),
        .rsp_vld   (pmp_ifu_rsp_vld),
        .rsp_deny  (pmp_ifu_deny),
        .acc       (ifu_acc),
        .acc_deny  (ifu_acc_deny),
        .acc_nohit (ifu_acc_nohit),
        .acc_idx   (ifu_acc_idx)
    );

    cr_pmp_chk_chan #(.NREG(NREG), .IDXW(IDXW)) u_lsu_chan (
        .clk       (forever_cpuclk),
        .rst_n     (cpurst_b),
        .req_vld   (lsu_pmp_req_vld),
        .req_rdy   (lsu_pmp_req_rdy),
        .hit       (lsu_pmp_hit),
        .perm      (lsu_pmp_is_st ? regs_comp_write : regs_comp_read),
        .lock      (regs_comp_lock),
        .priv_m    (lsu_priv_m),
        .rsp_rdy   (lsu_pmp_rsp_rdy),
        .rsp_vld   (pmp_lsu_rsp_vld),
        .rsp_deny  (pmp_lsu_deny),
        .acc       (lsu_acc),
        .acc_deny  (lsu_acc_deny),
        .acc_nohit (lsu_acc_nohit),
        .acc_idx   (lsu_acc_idx)
    );

    assign ifu_den = ifu_acc && ifu_acc_deny;
    assign lsu_den = lsu_acc && lsu_acc_deny;

    // A clear in the same cycle as a deny empties the record first, so the new fault lands.
    always_comb begin
        rec_vld_base = rec_vld_q && !cp0_pmp_rec_clr;
        rec_vld_d    = rec_vld_base;
        rec_flags_d  = cp0_pmp_rec_clr ? '0 : rec_flags_q;
        rec_idx_d    = cp0_pmp_rec_clr ? '0 : rec_idx_q;
        if (!rec_vld_base && lsu_den) begin
            rec_vld_d         = 1'b1;
            rec_flags_d.lsu   = 1'b1;
            rec_flags_d.st    = lsu_pmp_is_st;
            rec_flags_d.nohit = lsu_acc_nohit;
            rec_idx_d         = lsu_acc_idx;
        end else if (!rec_vld_base && ifu_den) begin
            rec_vld_d         = 1'b1;
            rec_flags_d.lsu   = 1'b0;
            rec_flags_d.st    = 1'b0;
            rec_flags_d.nohit = ifu_acc_nohit;
            rec_idx_d         = ifu_acc_idx;
        end

        cnt_base = cp0_pmp_rec_clr ? '0 : cnt_q;
        cnt_sum  = {1'b0, cnt_base} + SUMW'(ifu_den) + SUMW'(lsu_den);
        cnt_d    = cnt_sum[CNTW] ? '1 : cnt_sum[CNTW-1:0];
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rec_vld_q   <= 1'b0;
            rec_flags_q <= '0;
            rec_idx_q   <= '0;
            cnt_q       <= '0;
        end else begin
            rec_vld_q   <= rec_vld_d;
            rec_flags_q <= rec_flags_d;
            rec_idx_q   <= rec_idx_d;
            cnt_q       <= cnt_d;
        end
    end

    assign pmp_cp0_rec_vld   = rec_vld_q;
    assign pmp_cp0_rec_lsu   = rec_flags_q.lsu;
    assign pmp_cp0_rec_st    = rec_flags_q.st;
    assign pmp_cp0_rec_nohit = rec_flags_q.nohit;
    assign pmp_cp0_rec_idx   = rec_idx_q;
    assign pmp_cp0_deny_cnt  = cnt_q;

endmodule
